// File: rtl/mso_capture_if.sv
// Sample stream and logical-address readback port of the trigger/capture block.
interface mso_capture_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10
);
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (output s_valid, output s_data, output rd_addr, input rd_data);
   modport slave  (input s_valid, input s_data, input rd_addr, output rd_data);
endinterface

// File: rtl/mso_trigger_capture.sv
// Level/edge triggered window capture into a circular RAM with pre-trigger depth.
// Optional timeout auto-trigger is enabled by defining MSO_CAPTURE_AUTO_EN.
module mso_trigger_capture #(
   parameter int DATA_WIDTH   = 12,
   parameter int ADDR_WIDTH   = 10,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   mso_capture_if.slave          bus,
   input  logic                  arm,
   input  logic                  disarm,
   input  logic                  force_trig,
   input  logic [DATA_WIDTH-1:0] trig_level,
   input  logic                  trig_falling,
   input  logic [ADDR_WIDTH-1:0] pretrig,
   output logic                  busy,
   output logic                  triggered,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  trig_auto
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PRE_MAX = ADDR_WIDTH'(DEPTH - 2);

   typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
   logic [ADDR_WIDTH-1:0] cnt, cnt_n;
   logic [ADDR_WIDTH-1:0] pre_eff, pre_eff_n;
   logic [DATA_WIDTH-1:0] prev, prev_n;
   logic                  prev_vld, prev_vld_n;
   logic                  pend, pend_n;
   logic                  triggered_n, trig_auto_n;
   logic [ADDR_WIDTH-1:0] trig_addr_n;
   logic                  we;
   logic                  edge_hit, auto_hit;
   logic [ADDR_WIDTH-1:0] pre_clamp, post_len, cnt_inc, win_start;

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   assign pre_clamp = (pretrig > PRE_MAX) ? PRE_MAX : pretrig;
   assign post_len  = {ADDR_WIDTH{1'b1}} - pre_eff;
   assign cnt_inc   = cnt + 1'b1;
   assign win_start = trig_addr - pre_eff;

   assign edge_hit = prev_vld && (trig_falling ?
                     (prev >= trig_level && bus.s_data <  trig_level) :
                     (prev <  trig_level && bus.s_data >= trig_level));

`ifdef MSO_CAPTURE_AUTO_EN
   localparam int ATW = $clog2(AUTO_TIMEOUT + 1);
   logic [ATW-1:0] auto_cnt;
   logic           enter_wait;

   // A re-arm straight into WAIT_TRIG also counts as a fresh entry.
   assign enter_wait = (state_n == WAIT_TRIG) &&
                       ((state != WAIT_TRIG) || (arm && !disarm));
   assign auto_hit   = (state == WAIT_TRIG) && (auto_cnt == ATW'(AUTO_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst)                                  auto_cnt <= '0;
      else if (enter_wait)                      auto_cnt <= '0;
      else if (state == WAIT_TRIG && bus.s_valid) auto_cnt <= auto_cnt + 1'b1;
   end
`else
   assign auto_hit = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      wr_ptr_n    = wr_ptr;
      cnt_n       = cnt;
      pre_eff_n   = pre_eff;
      prev_n      = prev;
      prev_vld_n  = prev_vld;
      pend_n      = pend;
      triggered_n = triggered;
      trig_addr_n = trig_addr;
      trig_auto_n = trig_auto;
      we          = 1'b0;
      if (disarm) begin
         state_n     = IDLE;
         triggered_n = 1'b0;
         trig_auto_n = 1'b0;
         pend_n      = 1'b0;
      end else if (arm) begin
         state_n     = (pre_clamp == '0) ? WAIT_TRIG : PRE_FILL;
         wr_ptr_n    = '0;
         cnt_n       = '0;
         pre_eff_n   = pre_clamp;
         prev_vld_n  = 1'b0;
         triggered_n = 1'b0;
         trig_auto_n = 1'b0;
         pend_n      = 1'b0;
      end else if (busy && bus.s_valid) begin
         we         = 1'b1;
         wr_ptr_n   = wr_ptr + 1'b1;
         prev_n     = bus.s_data;
         prev_vld_n = 1'b1;
         case (state)
            PRE_FILL: begin
               cnt_n = cnt_inc;
               if (cnt_inc == pre_eff) begin
                  state_n = WAIT_TRIG;
                  cnt_n   = '0;
               end
            end
            WAIT_TRIG: begin
               if (edge_hit || force_trig || auto_hit) begin
                  state_n     = POST_FILL;
                  trig_addr_n = wr_ptr;
                  triggered_n = 1'b1;
                  trig_auto_n = auto_hit && !(edge_hit || force_trig);
                  cnt_n       = '0;
               end
            end
            POST_FILL: begin
               // A forced trigger without a sample defers the trigger sample to here.
               if (pend) begin
                  pend_n      = 1'b0;
                  trig_addr_n = wr_ptr;
               end else begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == post_len) state_n = DONE;
               end
            end
            default: ;
         endcase
      end else if (state == WAIT_TRIG && force_trig) begin
         state_n     = POST_FILL;
         triggered_n = 1'b1;
         trig_auto_n = 1'b0;
         pend_n      = 1'b1;
         cnt_n       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         cnt       <= '0;
         pre_eff   <= '0;
         prev      <= '0;
         prev_vld  <= 1'b0;
         pend      <= 1'b0;
         triggered <= 1'b0;
         trig_addr <= '0;
         trig_auto <= 1'b0;
      end else begin
         state     <= state_n;
         wr_ptr    <= wr_ptr_n;
         cnt       <= cnt_n;
         pre_eff   <= pre_eff_n;
         prev      <= prev_n;
         prev_vld  <= prev_vld_n;
         pend      <= pend_n;
         triggered <= triggered_n;
         trig_addr <= trig_addr_n;
         trig_auto <= trig_auto_n;
      end
   end

   always_ff @(posedge clk) begin
      if (we) ram[wr_ptr] <= bus.s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) bus.rd_data <= '0;
      else     bus.rd_data <= ram[win_start + bus.rd_addr];
   end

   assign busy = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST_FILL);
   assign done = (state == DONE);
endmodule

// File: tb/tb_mso_trigger_capture.sv
// Bench for mso_trigger_capture with a 16-entry buffer: table of capture scenarios plus corner sequences.
module tb_mso_trigger_capture;
   localparam int DW = 12;
   localparam int AW = 4;

   typedef struct {
      int level; int falling; int pretrig; int gap;
      int hold; int start; int step;
      int trigk; int rd0; int trigval;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arm = 1'b0, disarm = 1'b0, force_trig = 1'b0;
   logic [DW-1:0] trig_level = '0;
   logic          trig_falling = 1'b0;
   logic [AW-1:0] pretrig = '0;
   logic          busy, triggered, done, trig_auto;
   logic [AW-1:0] trig_addr;

   mso_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mso_trigger_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTO_TIMEOUT(20)) dut (
      .clk(clk), .rst(rst), .bus(bus), .arm(arm), .disarm(disarm),
      .force_trig(force_trig), .trig_level(trig_level), .trig_falling(trig_falling),
      .pretrig(pretrig), .busy(busy), .triggered(triggered), .done(done),
      .trig_addr(trig_addr), .trig_auto(trig_auto)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int exp_q[$];
   int mdl[16];
   vec_t vecs[5];

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input int d);
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = DW'(d);
         step();
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   function automatic int sample(input vec_t v, input int k);
      int d;
      if (k < v.hold) d = k % 50;
      else            d = v.start + v.step * (k - v.hold);
      if (d < 0)    d = 0;
      if (d > 4095) d = 4095;
      return d;
   endfunction

   task automatic run_vec(input vec_t v);
      int k, cyc, pre, need, taddr;
      bit vld;
      trig_level   = DW'(v.level);
      trig_falling = v.falling[0];
      pretrig      = AW'(v.pretrig);
      pre  = (v.pretrig > 14) ? 14 : v.pretrig;
      need = v.trigk + 1 + (15 - pre);
      k = 0;
      cyc = 0;
      pulse_arm();
      chk("busy_after_arm", int'(busy), 1);
      while (!done && cyc < 600) begin
         vld = (cyc % v.gap) == 0;
         bus.s_valid = vld;
         bus.s_data  = vld ? DW'(sample(v, k)) : '1;
         if (vld) begin
            mdl[k % 16] = sample(v, k);
            k++;
         end
         step();
         if (vld && k == v.trigk)     chk("trig_before", int'(triggered), 0);
         if (vld && k == v.trigk + 1) chk("trig_flag", int'(triggered), 1);
         cyc++;
      end
      bus.s_valid = 1'b0;
      chk("done_count", k, need);
      chk("done_flag", int'(done), 1);
      chk("busy_done", int'(busy), 0);
      taddr = v.trigk % 16;
      chk("trig_addr", int'(trig_addr), taddr);
      chk("trig_auto", int'(trig_auto), 0);
      feed(3, 4000);
      chk("done_hold", int'(done), 1);
      for (int i = 0; i < 16; i++) begin
         bus.rd_addr = AW'(i);
         exp_q.push_back(mdl[(taddr - pre + i) & 15]);
         step();
         chk("rd_window", int'(bus.rd_data), exp_q.pop_front());
         if (i == 0)   chk("rd_first", int'(bus.rd_data), v.rd0);
         if (i == pre) chk("rd_trig", int'(bus.rd_data), v.trigval);
      end
   endtask

   initial begin
      int nv;
      vecs[0] = '{level:100, falling:0, pretrig:4,  gap:1, hold:0,  start:0,  step:10,  trigk:10, rd0:60,  trigval:100};
      vecs[1] = '{level:50,  falling:1, pretrig:4,  gap:3, hold:0,  start:90, step:-10, trigk:5,  rd0:80,  trigval:40};
      vecs[2] = '{level:100, falling:0, pretrig:0,  gap:1, hold:0,  start:0,  step:10,  trigk:10, rd0:100, trigval:100};
      vecs[3] = '{level:200, falling:0, pretrig:15, gap:1, hold:0,  start:0,  step:10,  trigk:20, rd0:60,  trigval:200};
      vecs[4] = '{level:100, falling:0, pretrig:4,  gap:1, hold:40, start:200, step:1,  trigk:40, rd0:36,  trigval:200};
`ifdef MSO_CAPTURE_AUTO_EN
      nv = 4;
`else
      nv = 5;
`endif
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.rd_addr = '0;

      step();
      step();
      chk("rst_busy", int'(busy), 0);
      chk("rst_triggered", int'(triggered), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_trig_addr", int'(trig_addr), 0);
      chk("rst_trig_auto", int'(trig_auto), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      rst = 1'b0;

      // Reset in the middle of a capture
      trig_level = 12'd100;
      pretrig = 4'd4;
      pulse_arm();
      feed(2, 10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);

      for (int i = 0; i < nv; i++) run_vec(vecs[i]);

      // Forced trigger on a valid sample with flat data
      trig_level = 12'd100;
      trig_falling = 1'b0;
      pretrig = 4'd4;
      pulse_arm();
      feed(7, 50);
      force_trig = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data = 12'd50;
      step();
      force_trig = 1'b0;
      bus.s_valid = 1'b0;
      chk("force_trig_flag", int'(triggered), 1);
      chk("force_trig_addr", int'(trig_addr), 7);
      feed(10, 50);
      chk("force_not_done", int'(done), 0);
      feed(1, 50);
      chk("force_done", int'(done), 1);

      disarm = 1'b1;
      step();
      disarm = 1'b0;
      chk("disarm_done_clr", int'(done), 0);

      // Disarm while in POST_FILL
      pulse_arm();
      feed(4, 50);
      force_trig = 1'b1;
      step();
      force_trig = 1'b0;
      feed(2, 50);
      chk("post_busy", int'(busy), 1);
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      chk("disarm_busy", int'(busy), 0);
      chk("disarm_trig", int'(triggered), 0);
      chk("disarm_done", int'(done), 0);
      feed(20, 50);
      chk("idle_stays", int'(busy) + int'(done), 0);

      // Arm and disarm together
      arm = 1'b1;
      disarm = 1'b1;
      step();
      arm = 1'b0;
      disarm = 1'b0;
      chk("armdis_busy", int'(busy), 0);
      feed(20, 200);
      chk("armdis_idle", int'(busy) + int'(done), 0);

`ifdef MSO_CAPTURE_AUTO_EN
      trig_level = 12'd100;
      pretrig = 4'd4;
      pulse_arm();
      feed(4, 50);
      feed(19, 50);
      chk("auto_before", int'(triggered), 0);
      feed(1, 50);
      chk("auto_trig", int'(triggered), 1);
      chk("auto_flag", int'(trig_auto), 1);
      chk("auto_addr", int'(trig_addr), 7);
      feed(11, 50);
      chk("auto_done", int'(done), 1);
      run_vec(vecs[0]);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
